// File: rtl/srff_pulse_sched.sv
// Round-robin scheduler that sequences set/clear pulses onto a bank of srff flops and tracks their expected q.
// Optional build macro SRFF_SKIP_REDUNDANT_EN: requests that would not change the shadow complete without a pulse.

module srff_pulse_sched #(
    parameter int NREQ      = 4,
    parameter int NFF       = 6,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1,
    localparam int IDXW     = (NFF > 1) ? $clog2(NFF) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      ack,
    output logic                 ack_err,
    output logic [NFF-1:0]       s_out,
    output logic [NFF-1:0]       r_out,
    output logic [NFF-1:0]       shadow_q,
    output logic                 busy
);

    localparam int RRW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNTW = $clog2(PULSE_CYC + GAP_CYC + 2);

    typedef enum logic [2:0] {
        INIT_S   = 3'd0,
        INIT_GAP = 3'd1,
        IDLE     = 3'd2,
        ASSERT   = 3'd3,
        RELEASE  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [CNTW-1:0]     cnt_r, cnt_s;
    logic [RRW-1:0]      rr_r, rr_s;
    logic [RRW-1:0]      grant_r, grant_s;
    logic                op_r, op_s;
    logic [IDXW-1:0]     idx_r, idx_s;
    logic [NFF-1:0]      shadow_r, shadow_s;
    logic [NFF-1:0]      s_r, s_s;
    logic [NFF-1:0]      r_r, r_s;
    logic [NREQ-1:0]     ack_r, ack_s;
    logic                err_r, err_s;
    logic                busy_r;

    logic [RRW-1:0]      sel_s;
    logic                sel_found_s;
    logic [IDXW-1:0]     sel_idx_s;
    logic                sel_oob_s;

    function automatic logic [RRW-1:0] rr_wrap(input logic [RRW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        rr_wrap = RRW'((sum >= NREQ) ? (sum - NREQ) : sum);
    endfunction

    function automatic logic [NREQ-1:0] req_onehot(input logic [RRW-1:0] g);
        req_onehot    = '0;
        req_onehot[g] = 1'b1;
    endfunction

    function automatic logic [NFF-1:0] line_onehot(input logic [IDXW-1:0] i);
        line_onehot    = '0;
        line_onehot[i] = 1'b1;
    endfunction

    // Round-robin pick: first asserted request at or after the pointer, wrapping.
    always_comb begin
        sel_s       = '0;
        sel_found_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!sel_found_s && req[rr_wrap(rr_r, k)]) begin
                sel_found_s = 1'b1;
                sel_s       = rr_wrap(rr_r, k);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    assign sel_idx_s = req_idx[int'(sel_s)*IDXW +: IDXW];
    assign sel_oob_s = ({1'b0, sel_idx_s} >= (IDXW+1)'(NFF));

    // Next-state and next-output logic; the line drivers are computed here and registered below.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        rr_s     = rr_r;
        grant_s  = grant_r;
        op_s     = op_r;
        idx_s    = idx_r;
        shadow_s = shadow_r;
        s_s      = '0;
        r_s      = '0;
        ack_s    = '0;
        err_s    = 1'b0;
        case (state_r)
            INIT_S: begin
                // First cycle after reset is a lead-in with lines low, then PULSE_CYC cycles of s high.
                if (cnt_r == CNTW'(PULSE_CYC)) begin
                    state_s = INIT_GAP;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNTW'(1);
                    s_s   = '1;
                end
            end
            INIT_GAP: begin
                if (cnt_r == CNTW'(GAP_CYC - 1)) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNTW'(1);
                end
            end
            IDLE: begin
                if (sel_found_s) begin
                    grant_s = sel_s;
                    op_s    = req_op[sel_s];
                    idx_s   = sel_idx_s;
                    cnt_s   = '0;
                    if (sel_oob_s) begin
                        state_s = DONE;
                        ack_s   = req_onehot(sel_s);
                        err_s   = 1'b1;
                    end
`ifdef SRFF_SKIP_REDUNDANT_EN
                    else if (req_op[sel_s] == shadow_r[sel_idx_s]) begin
                        state_s = DONE;
                        ack_s   = req_onehot(sel_s);
                    end
`endif
                    else begin
                        state_s = ASSERT;
                        if (req_op[sel_s]) begin
                            s_s = line_onehot(sel_idx_s);
                        end else begin
                            r_s = line_onehot(sel_idx_s);
                        end
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ASSERT: begin
                if (cnt_r == CNTW'(PULSE_CYC - 1)) begin
                    state_s = RELEASE;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNTW'(1);
                    if (op_r) begin
                        s_s = line_onehot(idx_r);
                    end else begin
                        r_s = line_onehot(idx_r);
                    end
                end
            end
            RELEASE: begin
                if (cnt_r == CNTW'(GAP_CYC - 1)) begin
                    state_s         = DONE;
                    cnt_s           = '0;
                    ack_s           = req_onehot(grant_r);
                    shadow_s[idx_r] = op_r;
                end else begin
                    cnt_s = cnt_r + CNTW'(1);
                end
            end
            DONE: begin
                rr_s    = rr_wrap(grant_r, 1);
                state_s = IDLE;
            end
            default: begin
                state_s = INIT_S;
                cnt_s   = '0;
            end
        endcase
    end

    // State, latched transaction and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= INIT_S;
            cnt_r    <= '0;
            rr_r     <= '0;
            grant_r  <= '0;
            op_r     <= 1'b0;
            idx_r    <= '0;
            shadow_r <= '1;
            s_r      <= '0;
            r_r      <= '0;
            ack_r    <= '0;
            err_r    <= 1'b0;
            busy_r   <= 1'b1;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            rr_r     <= rr_s;
            grant_r  <= grant_s;
            op_r     <= op_s;
            idx_r    <= idx_s;
            shadow_r <= shadow_s;
            s_r      <= s_s;
            r_r      <= r_s;
            ack_r    <= ack_s;
            err_r    <= err_s;
            busy_r   <= (state_s != IDLE);
        end
    end

    assign s_out    = s_r;
    assign r_out    = r_r;
    assign ack      = ack_r;
    assign ack_err  = err_r;
    assign shadow_q = shadow_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_srff_pulse_sched.sv
// Bench for srff_pulse_sched: directed scenarios plus randomized transactions against a transaction-level model.

module tb_srff_pulse_sched;

    localparam int NREQ      = 4;
    localparam int NFF       = 6;
    localparam int PULSE_CYC = 2;
    localparam int GAP_CYC   = 1;
    localparam int IDXW      = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_op;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ-1:0]      ack;
    logic                 ack_err;
    logic [NFF-1:0]       s_out;
    logic [NFF-1:0]       r_out;
    logic [NFF-1:0]       shadow_q;
    logic                 busy;

    int total = 0;
    int bad   = 0;
    logic [NFF-1:0] shadow_m;
    int rr_m;

    always #5 clk = ~clk;

    srff_pulse_sched dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_idx(req_idx),
        .ack(ack), .ack_err(ack_err), .s_out(s_out), .r_out(r_out),
        .shadow_q(shadow_q), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 30) begin
            step();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL wait_idle: busy=%b required 0", busy); end
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_idle();
        shadow_m = '1;
        rr_m     = 0;
    endtask

    task automatic test_reset();
        int n;
        req = '0; req_op = '0; req_idx = '0;
        rst_n = 1'b0;
        step(); step();
        total++; if (s_out !== 6'b0 || r_out !== 6'b0) begin bad++; $display("FAIL rst_lines: s=%b r=%b required 0", s_out, r_out); end
        total++; if (ack !== 4'b0 || ack_err !== 1'b0) begin bad++; $display("FAIL rst_ack: ack=%b err=%b required 0", ack, ack_err); end
        total++; if (shadow_q !== 6'h3f) begin bad++; $display("FAIL rst_shadow: got %b required 111111", shadow_q); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy: got %b required 1", busy); end
        rst_n = 1'b1;
        n = 0;
        do begin step(); n++; end while (s_out === 6'b0 && n < 4);
        total++; if (s_out !== 6'h3f) begin bad++; $display("FAIL init_s1: s=%b required 111111", s_out); end
        total++; if (r_out !== 6'b0 || busy !== 1'b1 || shadow_q !== 6'h3f) begin bad++; $display("FAIL init_s1_misc: r=%b busy=%b sh=%b", r_out, busy, shadow_q); end
        step();
        total++; if (s_out !== 6'h3f || r_out !== 6'b0) begin bad++; $display("FAIL init_s2: s=%b r=%b required 111111/0", s_out, r_out); end
        step();
        total++; if (s_out !== 6'b0 || r_out !== 6'b0 || busy !== 1'b1) begin bad++; $display("FAIL init_gap: s=%b r=%b busy=%b required 0/0/1", s_out, r_out, busy); end
        step();
        total++; if (busy !== 1'b0 || s_out !== 6'b0) begin bad++; $display("FAIL init_idle: busy=%b s=%b required 0/0", busy, s_out); end
        shadow_m = '1;
        rr_m     = 0;
    endtask

    task automatic test_clear_basic();
        wait_idle();
        req_op = 4'b0000; req_idx = 12'h003; req = 4'b0001;
        step();
        total++; if (r_out !== 6'b001000 || s_out !== 6'b0) begin bad++; $display("FAIL clr_t1: r=%b s=%b required 001000/0", r_out, s_out); end
        step();
        total++; if (r_out !== 6'b001000 || s_out !== 6'b0) begin bad++; $display("FAIL clr_t2: r=%b s=%b required 001000/0", r_out, s_out); end
        step();
        total++; if (r_out !== 6'b0 || s_out !== 6'b0 || ack !== 4'b0) begin bad++; $display("FAIL clr_t3: r=%b s=%b ack=%b required 0", r_out, s_out, ack); end
        step();
        total++; if (ack !== 4'b0001 || ack_err !== 1'b0) begin bad++; $display("FAIL clr_ack: ack=%b err=%b required 0001/0", ack, ack_err); end
        total++; if (shadow_q !== 6'b110111) begin bad++; $display("FAIL clr_shadow: got %b required 110111", shadow_q); end
        req = '0;
        step();
        total++; if (ack !== 4'b0) begin bad++; $display("FAIL clr_ack_pulse: ack=%b required 0", ack); end
        shadow_m[3] = 1'b0;
        rr_m = 1;
    endtask

    task automatic test_error();
        wait_idle();
        req_op = 4'b0100; req_idx = 12'h1C0; req = 4'b0100;
        step();
        total++; if (ack !== 4'b0100 || ack_err !== 1'b1) begin bad++; $display("FAIL err_ack: ack=%b err=%b required 0100/1", ack, ack_err); end
        total++; if (s_out !== 6'b0 || r_out !== 6'b0) begin bad++; $display("FAIL err_lines: s=%b r=%b required 0", s_out, r_out); end
        total++; if (shadow_q !== 6'b110111) begin bad++; $display("FAIL err_shadow: got %b required 110111", shadow_q); end
        req = '0;
        step();
        total++; if (s_out !== 6'b0 || r_out !== 6'b0 || ack !== 4'b0 || ack_err !== 1'b0) begin bad++; $display("FAIL err_after: s=%b r=%b ack=%b err=%b required 0", s_out, r_out, ack, ack_err); end
        rr_m = 3;
    endtask

    task automatic test_arbitration();
        int got;
        int cyc;
        logic [3:0] exp_ack;
        do_reset();
        req_op = 4'b0000; req_idx = 12'h808; req = 4'b1010;
        got = 0; cyc = 0;
        while (got < 4 && cyc < 60) begin
            step();
            cyc++;
            total++; if ((s_out & r_out) !== 6'b0) begin bad++; $display("FAIL arb_excl: s=%b r=%b", s_out, r_out); end
            if (ack !== 4'b0) begin
                exp_ack = (got % 2 == 0) ? 4'b0010 : 4'b1000;
                total++; if (ack !== exp_ack) begin bad++; $display("FAIL arb_order: ack #%0d got %b required %b", got, ack, exp_ack); end
                got++;
            end
        end
        total++; if (got != 4) begin bad++; $display("FAIL arb_timeout: acks got %0d required 4", got); end
        req = '0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int n;
        wait_idle();
        req_op = 4'b0000; req_idx = 12'h003; req = 4'b0001;
        step();
        total++; if (r_out !== 6'b001000) begin bad++; $display("FAIL mid_assert: r=%b required 001000", r_out); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (r_out !== 6'b0 || s_out !== 6'b0 || ack !== 4'b0) begin bad++; $display("FAIL mid_drop: r=%b s=%b ack=%b required 0", r_out, s_out, ack); end
        total++; if (shadow_q !== 6'h3f || busy !== 1'b1) begin bad++; $display("FAIL mid_shadow: sh=%b busy=%b required 111111/1", shadow_q, busy); end
        req = '0;
        step();
        rst_n = 1'b1;
        n = 0;
        do begin step(); n++; end while (s_out === 6'b0 && n < 4);
        total++; if (s_out !== 6'h3f || ack !== 4'b0) begin bad++; $display("FAIL mid_reinit: s=%b ack=%b required 111111/0", s_out, ack); end
        wait_idle();
        total++; if (shadow_q !== 6'h3f) begin bad++; $display("FAIL mid_final_shadow: got %b required 111111", shadow_q); end
        shadow_m = '1;
        rr_m = 0;
    endtask

    task automatic test_skip_or_pulse();
        do_reset();
        req_op = 4'b0001; req_idx = 12'h000; req = 4'b0001;
`ifdef SRFF_SKIP_REDUNDANT_EN
        step();
        total++; if (ack !== 4'b0001 || ack_err !== 1'b0) begin bad++; $display("FAIL skip_ack: ack=%b err=%b required 0001/0", ack, ack_err); end
        total++; if (s_out !== 6'b0 || r_out !== 6'b0) begin bad++; $display("FAIL skip_lines: s=%b r=%b required 0", s_out, r_out); end
`else
        step();
        total++; if (s_out !== 6'b000001 || r_out !== 6'b0) begin bad++; $display("FAIL pulse_t1: s=%b r=%b required 000001/0", s_out, r_out); end
        step();
        total++; if (s_out !== 6'b000001) begin bad++; $display("FAIL pulse_t2: s=%b required 000001", s_out); end
        step();
        total++; if (s_out !== 6'b0 || ack !== 4'b0) begin bad++; $display("FAIL pulse_t3: s=%b ack=%b required 0", s_out, ack); end
        step();
        total++; if (ack !== 4'b0001 || shadow_q !== 6'h3f) begin bad++; $display("FAIL pulse_ack: ack=%b sh=%b required 0001/111111", ack, shadow_q); end
`endif
        req = '0;
        wait_idle();
        rr_m = 1;
    endtask

    task automatic test_random();
        logic [3:0]  rv, ov, exp_ack;
        logic [11:0] iv;
        logic [2:0]  ei;
        logic        eo;
        logic [5:0]  es, er, exp_shadow;
        bit          oob, skip, seen;
        int          g, lat, n, c;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            rv = 4'($urandom_range(1, 15));
            ov = 4'($urandom);
            iv = 12'($urandom);
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                c = (rr_m + k) % NREQ;
                if (g < 0 && rv[c]) g = c;
            end
            ei   = iv[g*IDXW +: IDXW];
            eo   = ov[g];
            oob  = (int'(ei) >= NFF);
            skip = 1'b0;
`ifdef SRFF_SKIP_REDUNDANT_EN
            skip = !oob && (shadow_m[ei] == eo);
`endif
            lat = (oob || skip) ? 1 : PULSE_CYC + GAP_CYC + 1;
            exp_shadow = shadow_m;
            if (!oob) exp_shadow[ei] = eo;
            exp_ack = 4'b0001 << g;
            req_op = ov; req_idx = iv; req = rv;
            seen = 1'b0; n = 0;
            while (!seen && n < 12) begin
                step();
                n++;
                if (n == 1) begin req_op = 4'($urandom); req_idx = 12'($urandom); end
                es = '0; er = '0;
                if (!oob && !skip && n <= PULSE_CYC) begin
                    if (eo) es[ei] = 1'b1; else er[ei] = 1'b1;
                end
                total++; if (s_out !== es || r_out !== er) begin bad++; $display("FAIL rnd_lines: txn %0d cyc %0d s=%b r=%b required %b/%b", t, n, s_out, r_out, es, er); end
                if (ack !== 4'b0) begin
                    seen = 1'b1;
                    total++; if (n != lat) begin bad++; $display("FAIL rnd_latency: txn %0d got %0d required %0d", t, n, lat); end
                    total++; if (ack !== exp_ack || ack_err !== oob) begin bad++; $display("FAIL rnd_ack: txn %0d ack=%b err=%b required %b/%b", t, ack, ack_err, exp_ack, oob); end
                    total++; if (shadow_q !== exp_shadow) begin bad++; $display("FAIL rnd_shadow: txn %0d got %b required %b", t, shadow_q, exp_shadow); end
                end
            end
            total++; if (!seen) begin bad++; $display("FAIL rnd_timeout: txn %0d no ack within 12 cycles", t); end
            req = '0;
            shadow_m = exp_shadow;
            rr_m = (g + 1) % NREQ;
            wait_idle();
        end
    endtask

    initial begin
        test_reset();
        test_clear_basic();
        test_error();
        test_arbitration();
        test_reset_mid();
        test_skip_or_pulse();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
